// File: rtl/freq_tone_gen.sv
// Square-wave generator whose frequency rises linearly with a level code.
// Optional macro INPUT_SYNC_EN adds a two-stage input register before capture.
module freq_tone_gen #(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned LOW_FREQ   = 1_000,
  parameter int unsigned HIGH_FREQ  = 20_000_000,
  parameter int unsigned INPUT_BITS = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [INPUT_BITS-1:0] INPUT_VALUE,
  output logic                  FREQ_OUT
);

  localparam int unsigned DW     = 32;
  localparam int unsigned IW     = 5;
  localparam int unsigned FSTEP  = (HIGH_FREQ - LOW_FREQ) / ((32'd1 << INPUT_BITS) - 32'd1);
  localparam int unsigned HP_RST = CLOCK_FREQ / (2 * LOW_FREQ);
  localparam int unsigned CW     = $clog2(HP_RST + 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  state_t state_q, state_d;
  logic   load_c, step_c, commit_c;

  logic [INPUT_BITS-1:0] v_src;
  logic [DW-1:0]         divisor_q, quot_q, rem_q;
  logic [IW-1:0]         iter_q;
  logic [DW-1:0]         f_c, divisor_c, diff_c;
  logic [DW:0]           rem_shift_c;
  logic                  ge_c;
  logic [CW-1:0]         hp_clamped_c;
  logic [CW-1:0]         hp_pending, hp_act, cnt;

`ifdef INPUT_SYNC_EN
  logic [INPUT_BITS-1:0] sync_q1, sync_q2;

  // Two-stage register on the level code before it is captured.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= INPUT_VALUE;
      sync_q2 <= sync_q1;
    end
  end
  assign v_src = sync_q2;
`else
  assign v_src = INPUT_VALUE;
`endif

  assign f_c       = DW'(LOW_FREQ) + DW'(FSTEP) * DW'(v_src);
  assign divisor_c = f_c << 1;

  // One restoring-division step: shift in next dividend bit, subtract if it fits.
  assign rem_shift_c = {rem_q, quot_q[DW-1]};
  assign ge_c        = rem_shift_c >= {1'b0, divisor_q};
  assign diff_c      = rem_shift_c[DW-1:0] - divisor_q;

  always_comb begin
    hp_clamped_c = CW'(quot_q);
    if (quot_q == '0) begin
      hp_clamped_c = CW'(1);
    end else if (quot_q > DW'(HP_RST)) begin
      hp_clamped_c = CW'(HP_RST);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_DIV;
      S_DIV:   if (iter_q == IW'(DW - 1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load_c   = 1'b0;
    step_c   = 1'b0;
    commit_c = 1'b0;
    case (state_q)
      S_IDLE:  load_c   = 1'b1;
      S_DIV:   step_c   = 1'b1;
      S_DONE:  commit_c = 1'b1;
      default: ;
    endcase
  end

  // Divider datapath; the quotient accumulates in place of the dividend.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      divisor_q <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      iter_q    <= '0;
    end else if (load_c) begin
      divisor_q <= divisor_c;
      quot_q    <= DW'(CLOCK_FREQ);
      rem_q     <= '0;
      iter_q    <= '0;
    end else if (step_c) begin
      quot_q <= {quot_q[DW-2:0], ge_c};
      rem_q  <= ge_c ? diff_c : rem_shift_c[DW-1:0];
      iter_q <= iter_q + IW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)        hp_pending <= CW'(HP_RST);
    else if (commit_c) hp_pending <= hp_clamped_c;
  end

  // New half-period is adopted only at a toggle, so levels are never truncated.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      FREQ_OUT <= 1'b0;
      cnt      <= '0;
      hp_act   <= CW'(HP_RST);
    end else if (cnt == hp_act - CW'(1)) begin
      FREQ_OUT <= ~FREQ_OUT;
      cnt      <= '0;
      hp_act   <= hp_pending;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_freq_tone_gen.sv
// Bench for freq_tone_gen: measures output level lengths against an arithmetic model.
module tb_freq_tone_gen;

  localparam int unsigned CLOCK_FREQ = 50_000_000;
  localparam int unsigned LOW_FREQ   = 1_000;
  localparam int unsigned HIGH_FREQ  = 20_000_000;
  localparam int unsigned NBITS      = 8;
  localparam int          BOUND      = 30000;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic [NBITS-1:0] INPUT_VALUE;
  logic             FREQ_OUT;

  int errors = 0;
  int checks = 0;

  freq_tone_gen #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .LOW_FREQ   (LOW_FREQ),
    .HIGH_FREQ  (HIGH_FREQ),
    .INPUT_BITS (NBITS)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .INPUT_VALUE (INPUT_VALUE),
    .FREQ_OUT    (FREQ_OUT)
  );

  always #10 CLK = ~CLK;

  function automatic int hp_model(input int v);
    longint fstep, f, hp;
    fstep = longint'((HIGH_FREQ - LOW_FREQ) / ((1 << NBITS) - 1));
    f     = longint'(LOW_FREQ) + fstep * longint'(v);
    hp    = longint'(CLOCK_FREQ) / (2 * f);
    if (hp < 1) hp = 1;
    return int'(hp);
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts negedges until FREQ_OUT differs from its value at entry.
  task automatic wait_toggle(output int n);
    logic start;
    start = FREQ_OUT;
    n = 0;
    while (n < BOUND) begin
      @(negedge CLK);
      n++;
      if (FREQ_OUT !== start) return;
    end
    check("toggle_timeout", n, -1);
    n = -1;
  endtask

  // Applies a code, lets it commit and reach a toggle, then returns one level length.
  task automatic apply_and_measure(input int v, output int hp);
    int n;
    INPUT_VALUE = NBITS'(v);
    repeat (80) @(negedge CLK);
    wait_toggle(n);
    wait_toggle(n);
    hp = n;
  endtask

  initial begin
    int n, hp, prev, v;
    string tag;

    RST_N       = 1'b0;
    INPUT_VALUE = '0;
    #200;
    @(negedge CLK);
    check("out_in_reset", int'(FREQ_OUT), 0);
    RST_N = 1'b1;

    wait_toggle(n);
    check("first_low_v0", n, 25000);
    check("level_after_first", int'(FREQ_OUT), 1);

    // Code change mid-level: current high level must still last in full.
    repeat (100) @(negedge CLK);
    INPUT_VALUE = 8'd255;
    wait_toggle(n);
    check("full_high_on_change", n + 100, 25000);
    for (int i = 0; i < 4; i++) begin
      wait_toggle(n);
      check($sformatf("v255_level%0d", i), n, hp_model(255));
    end

    apply_and_measure(128, hp);
    check("v128_hp", hp, 2);
    wait_toggle(n);
    check("v128_duty", n, 2);

    apply_and_measure(1, hp);
    check("v1_hp", hp, 314);
    wait_toggle(n);
    check("v1_duty", n, 314);

    prev = 1 << 30;
    for (int c = 200; c <= 255; c += 5) begin
      apply_and_measure(c, hp);
      tag = $sformatf("sweep_v%0d", c);
      check(tag, hp, hp_model(c));
      check({tag, "_mono"}, int'(hp <= prev), 1);
      prev = hp;
    end

    for (int i = 0; i < 10; i++) begin
      v = int'($urandom_range(16, 255));
      apply_and_measure(v, hp);
      wait_toggle(n);
      check($sformatf("rand_v%0d_hi", v), hp, hp_model(v));
      check($sformatf("rand_v%0d_lo", v), n, hp_model(v));
    end

    // Reset while output is high and the divider is busy.
    INPUT_VALUE = 8'd200;
    repeat (10) @(negedge CLK);
    n = 0;
    while (FREQ_OUT !== 1'b1 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("high_before_reset", int'(FREQ_OUT), 1);
    #2 RST_N = 1'b0;
    #1 check("async_reset_out", int'(FREQ_OUT), 0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    wait_toggle(n);
    check("first_low_after_reset", n, 25000);
    wait_toggle(n);
    check("v200_after_reset", n, hp_model(200));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
